freq_meter: RTL

FREQ_METER -- requirements
Module: freq_meter

---
 rtl/freq_meter_pkg.sv | 19 +
 rtl/freq_meter_sync_edge.sv | 40 ++++
 rtl/freq_meter.sv | 172 +++++++++++++++++
 3 files changed

// File: rtl/freq_meter_pkg.sv
// freq_meter_pkg
//   Shared definitions for the frequency meter:
//   - DEFAULT_CLK_HZ : default system clock frequency in Hz
//   - SYNC_STAGES    : depth of the sig_in metastability synchronizer
//   - state_t        : gate-control FSM states (IDLE / GATE / DONE)
package freq_meter_pkg;

  localparam int unsigned DEFAULT_CLK_HZ = 50_000_000;

  // Two flops is enough for a single-bit level crossing into clk.
  localparam int unsigned SYNC_STAGES = 2;

  typedef enum logic [1:0] {
    IDLE = 2'd0,  // waiting for start or cont
    GATE = 2'd1,  // gate window open, counting edge pulses
    DONE = 2'd2   // single cycle: result published, valid high
  } state_t;

endpackage

// File: rtl/freq_meter_sync_edge.sv
// sync_edge
//   Brings an asynchronous level into the clk domain and emits a single-cycle
//   pulse for each rising edge.
//
//   Ports
//     clk   : system clock, rising-edge active
//     rst_n : asynchronous active-low reset, clears every flop
//     d     : asynchronous input level
//     rise  : one-cycle pulse, high in the third clk cycle after d rises
//             (two synchronizer flops plus a registered edge detector)
module sync_edge (
  input  logic clk,
  input  logic rst_n,
  input  logic d,
  output logic rise
);

  logic sync1_reg;    // metastability capture flop
  logic sync2_reg;    // first clean sample
  logic sync2_d_reg;  // previous clean sample, for edge detection
  logic rise_reg;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sync1_reg   <= 1'b0;
      sync2_reg   <= 1'b0;
      sync2_d_reg <= 1'b0;
      rise_reg    <= 1'b0;
    end else begin
      sync1_reg   <= d;
      sync2_reg   <= sync1_reg;
      sync2_d_reg <= sync2_reg;
      // Registered so the pulse is glitch-free and has a fixed latency.
      rise_reg    <= sync2_reg & ~sync2_d_reg;
    end
  end

  assign rise = rise_reg;

endmodule

// File: rtl/freq_meter.sv
// freq_meter
//   Counts rising edges of an asynchronous signal over a gate window of
//   GATE_CYCLES clk cycles. One-shot (start) or continuous (cont) operation,
//   with one cycle of dead time between back-to-back gates.
//
//   Parameters
//     CLK_HZ      : clk frequency in Hz
//     GATE_CYCLES : gate window length in clk cycles (>= 2)
//     CNT_W       : width of the edge counter and of freq
//
//   Ports
//     clk    : system clock, rising-edge active
//     rst_n  : asynchronous active-low reset
//     sig_in : measured signal, asynchronous to clk
//     start  : one-cycle request for a single measurement (ignored while busy)
//     cont   : continuous mode, re-arm automatically after every gate
//     busy   : high while a gate window is open
//     freq   : rising-edge count of the last completed gate
//     valid  : one-cycle pulse in the cycle freq/ovf update
//     ovf    : the last completed gate's count saturated
module freq_meter
  import freq_meter_pkg::*;
#(
  parameter int unsigned CLK_HZ      = DEFAULT_CLK_HZ,
  parameter int unsigned GATE_CYCLES = CLK_HZ,
  parameter int unsigned CNT_W       = 32
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             sig_in,
  input  logic             start,
  input  logic             cont,
  output logic             busy,
  output logic [CNT_W-1:0] freq,
  output logic             valid,
  output logic             ovf
);

  localparam int unsigned GW = $clog2(GATE_CYCLES);

  // Elaboration-time parameter checks.
  generate
    if (GATE_CYCLES < 2) begin : g_bad_gate
      $error("freq_meter: GATE_CYCLES must be at least 2");
    end
    if (CNT_W < 1) begin : g_bad_cnt_w
      $error("freq_meter: CNT_W must be at least 1");
    end
  endgenerate

  localparam logic [GW-1:0]    GATE_LAST = GW'(GATE_CYCLES - 1);
  localparam logic [CNT_W-1:0] CNT_MAX   = '1;

  // ---------------------------------------------------------------------
  // Input synchronizer and rising-edge detector
  // ---------------------------------------------------------------------
  logic edge_pulse;

  sync_edge u_sync_edge (
    .clk   (clk),
    .rst_n (rst_n),
    .d     (sig_in),
    .rise  (edge_pulse)
  );

  // ---------------------------------------------------------------------
  // State
  // ---------------------------------------------------------------------
  state_t           state_reg,    state_next;
  logic [GW-1:0]    gate_cnt_reg, gate_cnt_next;
  logic [CNT_W-1:0] edge_cnt_reg, edge_cnt_next;
  logic             ovf_flag_reg, ovf_flag_next;  // sticky, current gate
  logic [CNT_W-1:0] freq_reg,     freq_next;
  logic             ovf_reg,      ovf_next;

  // Edge count and overflow flag including this cycle's pulse. The counter
  // holds at CNT_MAX; a pulse arriving while it is already there is what
  // marks the gate as overflowed.
  logic [CNT_W-1:0] edge_acc;
  logic             flag_acc;

  always_comb begin
    edge_acc = edge_cnt_reg;
    flag_acc = ovf_flag_reg;
    if (edge_pulse) begin
      if (edge_cnt_reg == CNT_MAX) begin
        flag_acc = 1'b1;
      end else begin
        edge_acc = edge_cnt_reg + 1'b1;
      end
    end
  end

  // Next-state and datapath control.
  always_comb begin
    state_next    = state_reg;
    gate_cnt_next = gate_cnt_reg;
    edge_cnt_next = edge_cnt_reg;
    ovf_flag_next = ovf_flag_reg;
    freq_next     = freq_reg;
    ovf_next      = ovf_reg;

    case (state_reg)
      IDLE: begin
        // An edge pulse in this cycle is deliberately dropped: counting
        // starts with the first GATE cycle.
        if (start || cont) begin
          state_next    = GATE;
          gate_cnt_next = '0;
          edge_cnt_next = '0;
          ovf_flag_next = 1'b0;
        end
      end

      GATE: begin
        edge_cnt_next = edge_acc;
        ovf_flag_next = flag_acc;
        if (gate_cnt_reg == GATE_LAST) begin
          // Publish on the way into DONE so freq/ovf are already the new
          // values while valid is high. The last gate cycle's pulse is
          // included through edge_acc/flag_acc.
          state_next = DONE;
          freq_next  = edge_acc;
          ovf_next   = flag_acc;
        end else begin
          gate_cnt_next = gate_cnt_reg + 1'b1;
        end
      end

      DONE: begin
        // The single dead cycle: a pulse here belongs to no gate.
        if (start || cont) begin
          state_next    = GATE;
          gate_cnt_next = '0;
          edge_cnt_next = '0;
          ovf_flag_next = 1'b0;
        end else begin
          state_next = IDLE;
        end
      end

      default: begin
        state_next = IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_reg    <= IDLE;
      gate_cnt_reg <= '0;
      edge_cnt_reg <= '0;
      ovf_flag_reg <= 1'b0;
      freq_reg     <= '0;
      ovf_reg      <= 1'b0;
    end else begin
      state_reg    <= state_next;
      gate_cnt_reg <= gate_cnt_next;
      edge_cnt_reg <= edge_cnt_next;
      ovf_flag_reg <= ovf_flag_next;
      freq_reg     <= freq_next;
      ovf_reg      <= ovf_next;
    end
  end

  // start is only looked at in IDLE/DONE, so a start while busy is dropped.
  assign busy  = (state_reg == GATE);
  assign valid = (state_reg == DONE);
  assign freq  = freq_reg;
  assign ovf   = ovf_reg;

endmodule
